// File: rtl/ex_pkg.sv
// Shared constants and entry layout for the execute-to-memory result buffer.
package ex_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  localparam int CW_DEF = 16;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [DW_DEF-1:0] result;
    logic [RW_DEF-1:0] rd;
    logic              we;
    logic              zero;
  } ex_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/ex_result_buf.sv
// Two-entry skid buffer between the shift/ALU stage and the memory stage.
// Define EX_RESULT_BUF_FWD_EN to add the youngest-entry bypass outputs.
module ex_result_buf
  import ex_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          out_zero,
  output logic [CW-1:0] stall_cnt
`ifdef EX_RESULT_BUF_FWD_EN
  ,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_result
`endif
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          we;
    logic          zero;
  } entry_t;

  entry_t     mem [DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;

  // Handshakes depend on stored occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: storage is reset because the head entry drives out_* directly and must read zero.
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) begin
        mem[wr_ptr].result <= in_result;
        mem[wr_ptr].rd     <= in_rd;
        mem[wr_ptr].we     <= in_we & (in_rd != '0);
        mem[wr_ptr].zero   <= (in_result == '0);
        wr_ptr             <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

  assign out_result = mem[rd_ptr].result;
  assign out_rd     = mem[rd_ptr].rd;
  assign out_we     = mem[rd_ptr].we;
  assign out_zero   = mem[rd_ptr].zero;

`ifdef EX_RESULT_BUF_FWD_EN
  // Youngest entry sits just behind the write pointer; gated to zero when the buffer is empty.
  assign fwd_valid  = out_valid & mem[~wr_ptr].we;
  assign fwd_rd     = out_valid ? mem[~wr_ptr].rd : '0;
  assign fwd_result = out_valid ? mem[~wr_ptr].result : '0;
`endif

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_ex_result_buf.sv
// Scoreboard bench for ex_result_buf: queue-based reference model, directed cases, random traffic.
module tb_ex_result_buf;
  import ex_pkg::*;

  localparam int DW = DW_DEF;
  localparam int RW = RW_DEF;
  localparam int CW = CW_DEF;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_we;
  logic [DW-1:0] in_result;
  logic [RW-1:0] in_rd;
  logic          out_valid, out_ready, out_we, out_zero;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic [CW-1:0] stall_cnt;
`ifdef EX_RESULT_BUF_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_result;
`endif

  ex_result_buf #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_zero   (out_zero),
    .stall_cnt  (stall_cnt)
`ifdef EX_RESULT_BUF_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_result (fwd_result)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of in-flight entries plus a stall tally.
  ex_entry_t     m_q[$];
  logic [CW-1:0] m_stall = '0;
  bit            mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs settle 1ns after posedge, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic int        sz = m_q.size();
      automatic ex_entry_t e;
      check("in_ready", in_ready, sz != DEPTH);
      check("out_valid", out_valid, sz != 0);
      check("stall_cnt", stall_cnt, m_stall);
`ifdef EX_RESULT_BUF_FWD_EN
      check("fwd_valid", fwd_valid, (sz != 0) && m_q[sz-1].we);
      if (sz != 0) begin
        check("fwd_rd", fwd_rd, m_q[sz-1].rd);
        check("fwd_result", fwd_result, m_q[sz-1].result);
      end
`endif
      if (out_valid && out_ready) begin
        if (sz == 0) begin
          check("pop_when_empty", out_valid, 1'b0);
        end else begin
          e = m_q.pop_front();
          check("out_result", out_result, e.result);
          check("out_rd", out_rd, e.rd);
          check("out_we", out_we, e.we);
          check("out_zero", out_zero, e.zero);
        end
      end
      if (sz != 0 && !out_ready && m_stall != {CW{1'b1}})
        m_stall++;
      if (in_valid && sz != DEPTH && !flush) begin
        e.result = in_result;
        e.rd     = in_rd;
        e.we     = in_we && (in_rd != 0);
        e.zero   = (in_result == 0);
        m_q.push_back(e);
      end
      if (flush)
        m_q.delete();
      if (reset) begin
        m_q.delete();
        m_stall = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry and hold it until the buffer accepts it (bounded).
  task automatic push_one(input logic [DW-1:0] d, input logic [RW-1:0] rd, input logic we);
    automatic bit accepted = 1'b0;
    in_valid  = 1'b1;
    in_result = d;
    in_rd     = rd;
    in_we     = we;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = in_ready;
      step();
    end
    check("push_accept", accepted, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_result"}, out_result, '0);
    check({tag, "_out_rd"}, out_rd, '0);
    check({tag, "_out_we"}, out_we, 1'b0);
    check({tag, "_out_zero"}, out_zero, 1'b0);
    check({tag, "_stall_cnt"}, stall_cnt, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0;
    in_rd = '0; in_we = 1'b0; out_ready = 1'b0;
    step(); step();
    reset  = 1'b0;
    mon_en = 1'b1;
    check_reset_state("rst");
    step(); step();
    check_reset_state("idle");

    // Single push, consumed immediately.
    out_ready = 1'b1;
    push_one(32'h0000FFFF, 5'd5, 1'b1);
    check("single_valid", out_valid, 1'b1);
    check("single_result", out_result, 32'h0000FFFF);
    check("single_rd", out_rd, 5'd5);
    check("single_we", out_we, 1'b1);
    check("single_zero", out_zero, 1'b0);
    step();
    check("single_empty", out_valid, 1'b0);

    // Backpressure fills both slots; third offer is held.
    out_ready = 1'b0;
    push_one(32'hFFFFFFFE, 5'd7, 1'b1);
    push_one(32'h00000000, 5'd8, 1'b0);
    check("bp_full", in_ready, 1'b0);
    in_valid = 1'b1; in_result = 32'h33; in_rd = 5'd9; in_we = 1'b1;
    step(); step();
    check("bp_stall3", stall_cnt, 16'd3);
    check("bp_head", out_result, 32'hFFFFFFFE);
    out_ready = 1'b1;
    push_one(32'h33, 5'd9, 1'b1);
    repeat (4) step();

    // Register 0 is never written.
    push_one(32'h1, 5'd0, 1'b1);
    check("rd0_we", out_we, 1'b0);
    check("rd0_result", out_result, 32'h1);
    step();

    // Streaming push+pop at occupancy 1.
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) begin
        check("stream_ready", in_ready, 1'b1);
        check("stream_valid", out_valid, 1'b1);
      end
      push_one(DW'(i), RW'(i), 1'b1);
    end
    repeat (2) step();

    // Flush at full with a simultaneous offer and a consumed pop.
    out_ready = 1'b0;
    push_one(32'hA1, 5'd1, 1'b1);
    push_one(32'hB2, 5'd2, 1'b1);
    in_valid = 1'b1; in_result = 32'hDEAD; in_rd = 5'd3; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_stall", stall_cnt, m_stall);

    // Flush at occupancy 1 drops a real push.
    out_ready = 1'b0;
    push_one(32'hC3, 5'd4, 1'b1);
    in_valid = 1'b1; in_result = 32'hE4; in_rd = 5'd6; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", out_valid, 1'b0);
    step(); step();

    // Reset wins over a simultaneous flush.
    out_ready = 1'b0;
    push_one(32'h77, 5'd10, 1'b1);
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    check_reset_state("rstflush");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_result = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      in_rd     = RW'($urandom_range(0, 31));
      in_we     = $urandom_range(0, 1) != 0;
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_result_buf.md
Name: ex_result_buf

Overview:
- Execute-to-memory result buffer directly downstream of the shift/ALU stage.
- Captures the 32-bit shift/ALU result with destination-register tag and write enable into a 2-entry FIFO (skid buffer).
- Presents entries to the memory stage under a valid/ready handshake, absorbing one cycle of backpressure without stalling the shifter combinationally.
- Also provides a registered zero flag per entry and a saturating stall counter for performance debug.

Parameters:
- DW, 32, result data width (matches shifter OUT).
- RW, 5, destination register index width.
- CW, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered entries (branch mispredict/exception).
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept this cycle.
- in_result  in  DW  shifter/ALU result.
- in_rd  in  RW  destination register.
- in_we  in  1  register write enable.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result  out  DW  head result.
- out_rd  out  RW  head destination.
- out_we  out  1  head write enable.
- out_zero  out  1  head result == 0.
- stall_cnt  out  CW  saturating count of backpressure cycles.

Behaviour:
- Storage: 2 entries {result, rd, we, zero}; wr_ptr, rd_ptr 1 bit each; count 0..2.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2); combinational from count only, never from out_ready.
- out_valid = (count != 0); out_* driven from entry[rd_ptr], registered storage only (no input-to-output combinational path).
- Latency: entry pushed in cycle N is visible on out_* in cycle N+1.
- Capture rules:
  - zero = (in_result == 0), computed at push.
  - we stored as in_we & (in_rd != 0); register 0 is never written.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count 1): count unchanged, both pointers advance.
  - Full (count 2): push impossible; pop frees a slot, and in_ready rises the next cycle.
  - Empty: pop impossible.
- Pointers wrap modulo 2.
- flush: next cycle count = 0 and pointers = 0. A simultaneous push is dropped; a simultaneous pop is still considered consumed downstream. Storage contents are don't-care.
- reset: has priority over flush. After reset:
  - count = 0, pointers = 0, storage cleared to 0.
  - out_valid = 0, out_result = 0, out_rd = 0, out_we = 0, out_zero = 0.
  - in_ready = 1, stall_cnt = 0.
- Reset mid-transfer discards all entries.
- stall_cnt: +1 each cycle with out_valid & !out_ready; saturates at all-ones. Cleared only by reset, not by flush.

Optional Feature:
- Macro EX_RESULT_BUF_FWD_EN.
- When defined, adds outputs fwd_valid (1), fwd_rd (RW), fwd_result (DW).
  - These present the youngest valid entry (entry[wr_ptr-1]) so decode can bypass.
  - fwd_valid = out_valid & youngest.we.
  - Same reset values as out_*; forced to 0 the cycle after flush.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ex_pkg holds:
  - constants DW_DEF=32, RW_DEF=5, CW_DEF=16, DEPTH=2.
  - packed entry typedef ex_entry_t {result, rd, we, zero}.
- One natural sub-module: sat_counter (parameterised width, enable, sync reset, saturate), instantiated for stall_cnt.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, all out_* = 0, stall_cnt = 0.
- Single push of in_result=32'h0000FFFF, rd=5, we=1 with out_ready=1: next cycle out_result=0000FFFF, out_rd=5, out_we=1, out_zero=0; following cycle out_valid=0.
- Backpressure: out_ready=0, push 32'hFFFFFFFE then 32'h00000000 → in_ready=0 after the second push, and the third push is held. After 3 stalled cycles stall_cnt=3. Release out_ready: outputs FFFFFFFE then 00000000 with out_zero=1, in order.
- Register-zero suppression: push rd=0, we=1, result=32'h1 → out_we=0.
- Simultaneous push+pop at count 1, repeated 10 cycles with streaming 32'h1..32'hA: count stays 1, outputs in order, no drops.
- Flush with count 2 plus a simultaneous push: next cycle out_valid=0 and in_ready=1, the pushed value never appears, and stall_cnt is unchanged. A reset asserted in the same cycle as flush yields reset values.
